// File: rtl/peripheral_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the serial engine state encoding used by both TX and RX.
package peripheral_pkg;

   localparam int unsigned OFF_DATA   = 0;
   localparam int unsigned OFF_STATUS = 1;

   localparam int unsigned ST_RX_NONEMPTY = 0;
   localparam int unsigned ST_TX_FULL     = 1;
   localparam int unsigned ST_OVERRUN     = 2;
   localparam int unsigned ST_TX_BUSY     = 3;
   localparam int unsigned ST_FRAME_ERR   = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

endpackage

// File: rtl/peripheral_uart_if.sv
// Peripheral bus between the core (master) and a slave with request/ready handshake.
interface peripheral_uart_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] address;
   logic              read_request;
   logic              write_request;
   logic [7:0]        data_write;
   logic [7:0]        data_read;
   logic              read_ready;
   logic              write_ready;

   modport master (
      output address, read_request, write_request, data_write,
      input  data_read, read_ready, write_ready
   );

   modport slave (
      input  address, read_request, write_request, data_write,
      output data_read, read_ready, write_ready
   );
endinterface

// File: rtl/peripheral_uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A push into a full FIFO succeeds
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_wptr == r_rptr);
   assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign rdata     = r_mem[r_rptr[AW-1:0]];

   // Pointer update; pointers wrap naturally through the extra MSB
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/peripheral_uart.sv
// Memory-mapped 8N1 UART: DATA/STATUS register window, RX/TX FIFOs and
// bit-level transmit and receive engines.
module peripheral_uart
   import peripheral_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(8'h10),
   parameter int unsigned       DIVISOR    = 868,
   parameter int unsigned       FIFO_DEPTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   peripheral_uart_if.slave       bus,
   input  logic                   uart_rx,
   output logic                   uart_tx
);
   localparam logic [15:0] BIT_TICKS  = 16'(DIVISOR - 1);
   localparam logic [15:0] HALF_TICKS = 16'(DIVISOR / 2 - 1);

   // Bus side
   logic [ADDR_W-1:0] w_offset;
   logic w_sel_data, w_sel_status, w_busy, w_rd_acc, w_wr_acc, w_stat_clr, w_tx_busy;
   logic [7:0] w_status;
   logic r_read_ready, r_write_ready, r_overrun, r_frame_err;
   logic [7:0] r_data_read;

   // FIFOs
   logic w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
   logic w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic [7:0] w_rx_rdata, w_tx_rdata;

   // TX engine
   uart_state_t r_tx_state, w_tx_state_d;
   logic [15:0] r_tx_cnt, w_tx_cnt_d;
   logic [2:0]  r_tx_bit, w_tx_bit_d;
   logic [7:0]  r_tx_shift, w_tx_shift_d;
   logic        r_tx_line, w_tx_line_d, w_tx_tick;

   // RX engine
   uart_state_t r_rx_state, w_rx_state_d;
   logic [15:0] r_rx_cnt, w_rx_cnt_d;
   logic [2:0]  r_rx_bit, w_rx_bit_d;
   logic [7:0]  r_rx_shift, w_rx_shift_d;
   logic [1:0]  r_rx_sync;
   logic        r_rx_prev, w_rx_line, w_rx_fall, w_rx_tick, w_rx_done_ok, w_rx_done_bad;
   logic        w_rx_overrun;

   assign w_offset     = bus.address - BASE_ADDR;
   assign w_sel_data   = (w_offset == ADDR_W'(OFF_DATA));
   assign w_sel_status = (w_offset == ADDR_W'(OFF_STATUS));
   // While a ready pulse is out, the master has not yet dropped its request
   assign w_busy       = r_read_ready | r_write_ready;
   assign w_rd_acc     = bus.read_request & (w_sel_data | w_sel_status) & ~w_busy;
   assign w_wr_acc     = bus.write_request & ~w_busy &
                         (w_sel_status | (w_sel_data & (~w_tx_full | w_tx_pop)));
   assign w_tx_push    = w_wr_acc & w_sel_data;
   assign w_rx_pop     = w_rd_acc & w_sel_data & ~w_rx_empty;
   assign w_stat_clr   = w_rd_acc & w_sel_status;
   assign w_tx_busy    = (r_tx_state != IDLE) | ~w_tx_empty;

   // STATUS register image
   always_comb begin
      w_status                 = '0;
      w_status[ST_RX_NONEMPTY] = ~w_rx_empty;
      w_status[ST_TX_FULL]     = w_tx_full;
      w_status[ST_OVERRUN]     = r_overrun;
      w_status[ST_TX_BUSY]     = w_tx_busy;
      w_status[ST_FRAME_ERR]   = r_frame_err;
   end

   assign bus.read_ready  = r_read_ready;
   assign bus.write_ready = r_write_ready;
   assign bus.data_read   = r_data_read;
   assign uart_tx         = r_tx_line;

   // Registered bus responses; data_read holds until the next completed read
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_read_ready  <= 1'b0;
         r_write_ready <= 1'b0;
         r_data_read   <= 8'h00;
      end else begin
         r_read_ready  <= w_rd_acc;
         r_write_ready <= w_wr_acc;
         if (w_rd_acc) r_data_read <= w_sel_data ? (w_rx_empty ? 8'h00 : w_rx_rdata) : w_status;
      end
   end

   // Sticky error flags: a new event beats a same-cycle clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_rx_overrun)     r_overrun <= 1'b1;
         else if (w_stat_clr)  r_overrun <= 1'b0;
         if (w_rx_done_bad)    r_frame_err <= 1'b1;
         else if (w_stat_clr)  r_frame_err <= 1'b0;
      end
   end

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_tx_push),
      .pop   (w_tx_pop),
      .wdata (bus.data_write),
      .rdata (w_tx_rdata),
      .full  (w_tx_full),
      .empty (w_tx_empty)
   );

   // A CPU pop frees the slot, so a full FIFO still accepts the byte
   assign w_rx_push    = w_rx_done_ok & (~w_rx_full | w_rx_pop);
   assign w_rx_overrun = w_rx_done_ok & w_rx_full & ~w_rx_pop;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_rx_push),
      .pop   (w_rx_pop),
      .wdata (r_rx_shift),
      .rdata (w_rx_rdata),
      .full  (w_rx_full),
      .empty (w_rx_empty)
   );

   assign w_tx_tick = (r_tx_cnt == '0);

   // TX next-state: each state lasts DIVISOR clocks; STOP chains straight into the next byte
   always_comb begin
      w_tx_state_d = r_tx_state;
      w_tx_cnt_d   = r_tx_cnt;
      w_tx_bit_d   = r_tx_bit;
      w_tx_shift_d = r_tx_shift;
      w_tx_pop     = 1'b0;
      unique case (r_tx_state)
         IDLE: begin
            if (!w_tx_empty) begin
               w_tx_pop     = 1'b1;
               w_tx_shift_d = w_tx_rdata;
               w_tx_cnt_d   = BIT_TICKS;
               w_tx_state_d = START;
            end
         end
         START: begin
            if (w_tx_tick) begin
               w_tx_cnt_d   = BIT_TICKS;
               w_tx_bit_d   = 3'd0;
               w_tx_state_d = DATA;
            end else begin
               w_tx_cnt_d = r_tx_cnt - 16'd1;
            end
         end
         DATA: begin
            if (w_tx_tick) begin
               w_tx_cnt_d   = BIT_TICKS;
               w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
               if (r_tx_bit == 3'd7) w_tx_state_d = STOP;
               else                  w_tx_bit_d   = r_tx_bit + 3'd1;
            end else begin
               w_tx_cnt_d = r_tx_cnt - 16'd1;
            end
         end
         STOP: begin
            if (w_tx_tick) begin
               if (!w_tx_empty) begin
                  w_tx_pop     = 1'b1;
                  w_tx_shift_d = w_tx_rdata;
                  w_tx_cnt_d   = BIT_TICKS;
                  w_tx_state_d = START;
               end else begin
                  w_tx_state_d = IDLE;
               end
            end else begin
               w_tx_cnt_d = r_tx_cnt - 16'd1;
            end
         end
         default: w_tx_state_d = IDLE;
      endcase
      case (w_tx_state_d)
         START:   w_tx_line_d = 1'b0;
         DATA:    w_tx_line_d = w_tx_shift_d[0];
         default: w_tx_line_d = 1'b1;
      endcase
   end

   // TX state register; the line output is registered so it is glitch-free
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tx_state <= IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_line  <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_d;
         r_tx_cnt   <= w_tx_cnt_d;
         r_tx_bit   <= w_tx_bit_d;
         r_tx_shift <= w_tx_shift_d;
         r_tx_line  <= w_tx_line_d;
      end
   end

   assign w_rx_line = r_rx_sync[1];
   assign w_rx_fall = r_rx_prev & ~w_rx_line;
   assign w_rx_tick = (r_rx_cnt == '0);

   // RX next-state: half-bit wait centres all later samples in their bit cells
   always_comb begin
      w_rx_state_d  = r_rx_state;
      w_rx_cnt_d    = r_rx_cnt;
      w_rx_bit_d    = r_rx_bit;
      w_rx_shift_d  = r_rx_shift;
      w_rx_done_ok  = 1'b0;
      w_rx_done_bad = 1'b0;
      unique case (r_rx_state)
         IDLE: begin
            if (w_rx_fall) begin
               w_rx_cnt_d   = HALF_TICKS;
               w_rx_state_d = START;
            end
         end
         START: begin
            if (w_rx_tick) begin
               if (w_rx_line) begin
                  w_rx_state_d = IDLE;
               end else begin
                  w_rx_cnt_d   = BIT_TICKS;
                  w_rx_bit_d   = 3'd0;
                  w_rx_state_d = DATA;
               end
            end else begin
               w_rx_cnt_d = r_rx_cnt - 16'd1;
            end
         end
         DATA: begin
            if (w_rx_tick) begin
               w_rx_cnt_d   = BIT_TICKS;
               w_rx_shift_d = {w_rx_line, r_rx_shift[7:1]};
               if (r_rx_bit == 3'd7) w_rx_state_d = STOP;
               else                  w_rx_bit_d   = r_rx_bit + 3'd1;
            end else begin
               w_rx_cnt_d = r_rx_cnt - 16'd1;
            end
         end
         STOP: begin
            if (w_rx_tick) begin
               w_rx_done_ok  = w_rx_line;
               w_rx_done_bad = ~w_rx_line;
               w_rx_state_d  = IDLE;
            end else begin
               w_rx_cnt_d = r_rx_cnt - 16'd1;
            end
         end
         default: w_rx_state_d = IDLE;
      endcase
   end

   // RX synchroniser, edge-detect history and state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rx_sync  <= 2'b11;
         r_rx_prev  <= 1'b1;
         r_rx_state <= IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_sync  <= {r_rx_sync[0], uart_rx};
         r_rx_prev  <= r_rx_sync[1];
         r_rx_state <= w_rx_state_d;
         r_rx_cnt   <= w_rx_cnt_d;
         r_rx_bit   <= w_rx_bit_d;
         r_rx_shift <= w_rx_shift_d;
      end
   end
endmodule

// File: doc/peripheral_uart.md
Name: peripheral_uart

Overview:
- Memory-mapped 8N1 serial port on the core's peripheral bus; the core is the bus master and this block is a slave.
- Decodes a two-register window (DATA, STATUS).
- Contains RX and TX FIFOs plus bit-level transmitter and receiver engines.
- Lets programs stream bytes over a serial line without cycle-accurate software timing.

Parameters:
ADDR_W, 8, width of the peripheral address
BASE_ADDR, 8'h10, address of DATA; STATUS is BASE_ADDR+1
DIVISOR, 868, clocks per serial bit (100 MHz / 115200); legal range 4..65535
FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_W  peripheral address from the core
read_request  in  1  read strobe, held by the master until read_ready
write_request  in  1  write strobe, held by the master until write_ready
data_write  in  8  write data
data_read  out  8  read data, valid while read_ready=1
read_ready  out  1  one-cycle read completion pulse
write_ready  out  1  one-cycle write completion pulse
uart_rx  in  1  serial input, asynchronous
uart_tx  out  1  serial output, idles high

Behaviour:
- Reset (async): uart_tx=1, read_ready=0, write_ready=0, data_read=0. Both FIFOs empty, sticky flags cleared, both engines IDLE.
- Decode: a request is accepted only when address is DATA or STATUS. Other addresses get no response; other slaves answer them.
- Handshake: a request is sampled at clock edge N. The ready pulse and data_read are registered and appear in cycle N+1. The block ignores requests in any cycle where its own ready output is high, so the master drops the request on seeing ready. data_read holds its value until the next read completes.
- read DATA: pops the RX FIFO. If the FIFO is empty, returns 8'h00 and still completes.
- write DATA: pushes the TX FIFO. If the TX FIFO is full, write_ready is withheld (the core stalls) until an entry frees. The push and the ack happen in the same cycle.
- read STATUS returns {3'b0, frame_err, tx_busy, overrun, tx_full, rx_nonempty} (bit0 = rx_nonempty). The read clears overrun and frame_err in the same cycle it is accepted; the returned value carries the pre-clear bits.
- write STATUS: acknowledged, data ignored.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE pops the FIFO when it is non-empty.
  - Each state lasts DIVISOR clocks, timed by a down-counter from DIVISOR-1 to 0.
  - DATA sends 8 bits LSB first, counted by a 3-bit counter.
  - After STOP, the next byte starts back-to-back with no extra idle bit.
  - tx_busy = (state != IDLE) or TX FIFO non-empty.
- RX input: uart_rx passes through a 2-flop synchroniser.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE detects a falling edge on the synchronised line.
  - START waits DIVISOR/2 (integer divide). If the line is high then, it is a false start and returns to IDLE.
  - DATA samples 8 bits at DIVISOR intervals, LSB first.
  - STOP samples the stop bit. If 1: push the byte, or drop it and set overrun if the FIFO is full. If 0: drop the byte and set frame_err.
  - The FSM returns to IDLE immediately after the STOP sample, ready for back-to-back frames.
- Simultaneous events:
  - CPU pop and RX push on a full RX FIFO in the same cycle: both succeed, no overrun.
  - CPU push and TX engine pop in the same cycle: both succeed.
  - Overrun set and STATUS read in the same cycle: the set wins.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and low bits are equal; empty = pointers equal.
- Reset mid-frame aborts both engines and forces uart_tx=1 asynchronously. A partial RX byte is discarded.

Decomposition:
- Package peripheral_pkg holds:
  - register offsets OFF_DATA=0, OFF_STATUS=1
  - status bit indices
  - typedef enum uart_state_t {IDLE, START, DATA, STOP}, shared by both FSMs
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, pop, wdata, rdata, full, empty), instantiated for RX and TX.

Test Plan (DIVISOR=4, FIFO_DEPTH=4):
- Write DATA 8'h55 -> write_ready one cycle after the request. uart_tx then shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each held 4 clocks. STATUS bit3 is 1 during the frame and 0 after.
- Loop uart_tx to uart_rx, write 8'hA3 -> STATUS reads 8'h01 after about 40 clocks. Read DATA returns 8'hA3, then STATUS reads 8'h00.
- Drive 5 valid RX frames with no reads -> STATUS reads 8'h05 (overrun, rx_nonempty). A second STATUS read returns 8'h01. DATA reads return the first 4 bytes, then 8'h00.
- Write 6 bytes back-to-back -> bytes 1-5 are acked promptly (the TX engine pops byte 1 immediately, leaving FIFO room for byte 5). Byte 6's write_ready stays low until byte 2 is popped after byte 1's frame. All 6 bytes appear in order on uart_tx.
- Pulse uart_rx low for 1 clock -> false start, nothing pushed. Send a frame with stop=0 -> STATUS bit4=1, FIFO empty.
- Assert reset mid-TX frame -> uart_tx=1 in the same cycle. After release, STATUS reads 8'h00. A request to address BASE_ADDR+2 gets no ready for 20 cycles.
